instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 16 +
 rtl/instr_loader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/instr_loader_pkg.sv
// Shared constants for the program loader: FSM state encoding and stream framing.
package instr_loader_pkg;

  // Loader FSM state encoding.
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StHdrHi = 3'd1;
  localparam logic [2:0] StHdrLo = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StErr   = 3'd5;

  // Stream framing: a 2-byte word count header, then 4-byte big-endian words.
  localparam int unsigned HdrBytes  = 2;
  localparam int unsigned WordBytes = 4;

endpackage

// File: rtl/instr_loader.sv
// Streams a length-prefixed program into instruction memory and holds the CPU
// in reset until a complete, valid image has been written.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          error
);

  logic [2:0]    state_q, state_d;
  logic [15:0]   n_q, n_d;         // word count from the header
  logic [15:0]   wcnt_q, wcnt_d;   // words written so far
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    bcnt_q, bcnt_d;   // byte position within the current word
  logic [31:0]   sr_q, sr_d;       // word assembly shift register
  logic [31:0]   wdata_q, wdata_d; // held separately so imem_wdata stays stable
  logic          we_q, we_d;

  logic          in_load;
  logic          accept;
  logic [15:0]   n_full;
  logic [15:0]   wcnt_inc;

  // Status decode from the current state; the write cycle blocks byte intake.
  always_comb begin
    in_load    = (state_q == StHdrHi) || (state_q == StHdrLo) || (state_q == StData);
    byte_ready = in_load && !we_q;
    accept     = byte_valid && byte_ready;
    busy       = in_load;
    done       = (state_q == StDone);
    error      = (state_q == StErr);
    cpu_rst    = (state_q != StDone);
    imem_we    = we_q;
    imem_addr  = addr_q;
    imem_wdata = wdata_q;
  end

  // Next-state logic for the loader FSM and its datapath.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    bcnt_d   = bcnt_q;
    sr_d     = sr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    n_full   = {n_q[15:8], byte_in};
    wcnt_inc = wcnt_q + 16'd1;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StHdrHi;
          n_d     = '0;
          wcnt_d  = '0;
          addr_d  = '0;
          bcnt_d  = '0;
          sr_d    = '0;
        end
      end

      StHdrHi: begin
        if (accept) begin
          n_d[15:8] = byte_in;
          state_d   = StHdrLo;
        end
      end

      StHdrLo: begin
        if (accept) begin
          n_d[7:0] = byte_in;
          if (n_full == 16'd0) begin
            state_d = StDone;
          end else if ({16'd0, n_full} > DEPTH) begin
            // Image would not fit; reject before touching memory.
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end

      StData: begin
        if (we_q) begin
          // Write cycle: advance address and count, finish after the last word.
          addr_d = addr_q + AW'(1);
          wcnt_d = wcnt_inc;
          if (wcnt_inc == n_q) begin
            state_d = StDone;
          end
        end else if (accept) begin
          sr_d   = {sr_q[23:0], byte_in};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'(WordBytes - 1)) begin
            we_d    = 1'b1;
            wdata_d = {sr_q[23:0], byte_in};
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      bcnt_q  <= '0;
      sr_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      bcnt_q  <= bcnt_d;
      sr_q    <= sr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

endmodule
